// File: rtl/quantize_drain.sv
// Drains accumulator diagonals from the systolic array, rounds/shifts/saturates each lane and emits SRAM writes.
// Optional QUANT_SAT_COUNT_EN adds a per-drain saturated-lane counter on sat_count.
module quantize_drain #(
    parameter int ARRAY_SIZE        = 16,
    parameter int ACC_WIDTH         = 40,
    parameter int OUTPUT_DATA_WIDTH = 24
) (
    input  logic                                    clk,
    input  logic                                    srstn,
    input  logic                                    start,
    input  logic [1:0]                              data_set_in,
    input  logic [4:0]                              shift_amt,
    input  logic                                    acc_valid,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]         acc_data,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    sram_write_enable,
    output logic [1:0]                              data_set,
    output logic [5:0]                              matrix_index,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data
`ifdef QUANT_SAT_COUNT_EN
    ,
    output logic [15:0]                             sat_count
`endif
);

    localparam logic [5:0] LAST_IDX = 6'(2*ARRAY_SIZE-2);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH+2-OUTPUT_DATA_WIDTH){1'b0}}, {(OUTPUT_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH+2-OUTPUT_DATA_WIDTH){1'b1}}, {(OUTPUT_DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]                              r_set;
    logic [4:0]                              r_shift;
    logic [5:0]                              r_cnt;
    logic [5:0]                              r_index;
    logic                                    r_we;
    logic                                    r_done;
    logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] r_q;
    logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] w_q;

    logic w_start;
    logic w_accept;
    logic w_last;

    assign w_start  = (r_state == S_IDLE)  && start;
    assign w_accept = (r_state == S_DRAIN) && acc_valid;
    assign w_last   = (r_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!srstn) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRAIN;
            S_DRAIN: if (acc_valid && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

`ifdef QUANT_SAT_COUNT_EN
    logic [15:0] r_sat;
    int          w_nsat;
    logic [16:0] w_sat_sum;
`endif

    // Add the half-LSB in ACC_WIDTH+1 bits so rounding can never overflow, then clamp.
    always_comb begin
        logic signed [ACC_WIDTH:0] w_ext;
        logic signed [ACC_WIDTH:0] w_rnd;
        logic signed [ACC_WIDTH:0] w_sum;
        logic signed [ACC_WIDTH:0] w_shf;
        w_q = '0;
`ifdef QUANT_SAT_COUNT_EN
        w_nsat = 0;
`endif
        w_rnd = (r_shift == 5'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (r_shift - 5'd1));
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            w_ext = {acc_data[i*ACC_WIDTH+ACC_WIDTH-1], acc_data[i*ACC_WIDTH +: ACC_WIDTH]};
            w_sum = w_ext + w_rnd;
            w_shf = w_sum >>> r_shift;
            if (w_shf > SAT_MAX) begin
                w_q[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = SAT_MAX[OUTPUT_DATA_WIDTH-1:0];
`ifdef QUANT_SAT_COUNT_EN
                w_nsat = w_nsat + 1;
`endif
            end else if (w_shf < SAT_MIN) begin
                w_q[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = SAT_MIN[OUTPUT_DATA_WIDTH-1:0];
`ifdef QUANT_SAT_COUNT_EN
                w_nsat = w_nsat + 1;
`endif
            end else begin
                w_q[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = w_shf[OUTPUT_DATA_WIDTH-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_set   <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_index <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
        end else begin
            r_we    <= 1'b0;
            r_index <= '0;
            r_q     <= '0;
            r_done  <= (r_state == S_DONE);
            if (w_start) begin
                r_set   <= data_set_in;
                r_shift <= shift_amt;
                r_cnt   <= '0;
            end
            if (w_accept) begin
                r_we    <= 1'b1;
                r_index <= r_cnt;
                r_q     <= w_q;
                if (!w_last) r_cnt <= r_cnt + 6'd1;
            end
        end
    end

`ifdef QUANT_SAT_COUNT_EN
    assign w_sat_sum = {1'b0, r_sat} + 17'(w_nsat);

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_sat <= '0;
        end else if (w_start) begin
            r_sat <= '0;
        end else if (w_accept) begin
            r_sat <= (w_sat_sum > 17'h0FFFF) ? 16'hFFFF : w_sat_sum[15:0];
        end
    end

    assign sat_count = r_sat;
`endif

    assign busy              = (r_state != S_IDLE) || r_done;
    assign done              = r_done;
    assign sram_write_enable = r_we;
    assign data_set          = r_set;
    assign matrix_index      = r_index;
    assign quantized_data    = r_q;

endmodule

// File: tb/tb_quantize_drain.sv
// Directed bench for quantize_drain: a transaction-level model checked every cycle, plus literal pins.
module tb_quantize_drain;
    localparam int N  = 16;
    localparam int AW = 40;
    localparam int OW = 24;
    localparam int LAST = 2*N-2;

    logic              clk = 1'b0;
    logic              srstn;
    logic              start;
    logic [1:0]        data_set_in;
    logic [4:0]        shift_amt;
    logic              acc_valid;
    logic [N*AW-1:0]   acc_data;
    logic              busy;
    logic              done;
    logic              sram_write_enable;
    logic [1:0]        data_set;
    logic [5:0]        matrix_index;
    logic [N*OW-1:0]   quantized_data;
`ifdef QUANT_SAT_COUNT_EN
    logic [15:0]       sat_count;
`endif

    quantize_drain #(.ARRAY_SIZE(N), .ACC_WIDTH(AW), .OUTPUT_DATA_WIDTH(OW)) dut (
        .clk               (clk),
        .srstn             (srstn),
        .start             (start),
        .data_set_in       (data_set_in),
        .shift_amt         (shift_amt),
        .acc_valid         (acc_valid),
        .acc_data          (acc_data),
        .busy              (busy),
        .done              (done),
        .sram_write_enable (sram_write_enable),
        .data_set          (data_set),
        .matrix_index      (matrix_index),
        .quantized_data    (quantized_data)
`ifdef QUANT_SAT_COUNT_EN
        ,
        .sat_count         (sat_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    longint lv [N];

    // Expected-output model: a drain is "idle", "running" (next index to write) or "ending" (last written).
    typedef enum {M_IDLE, M_RUN, M_END} phase_t;
    phase_t     m_phase;
    bit         m_started = 0;
    int         m_next;
    int         m_sh;
    int         m_sat;
    logic [1:0] m_set;
    logic       e_busy, e_done, e_we;
    int         e_idx;
    longint     e_q [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
        end
    endtask

    function automatic longint clamp(longint v);
        longint hi = (longint'(1) << (OW-1)) - 1;
        longint lo = -(longint'(1) << (OW-1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint rounded(longint a, int sh);
        if (sh == 0) return a;
        return (a + (longint'(1) << (sh-1))) >>> sh;
    endfunction

    function automatic logic [63:0] lane_out(int i);
        logic signed [OW-1:0] v;
        v = quantized_data[i*OW +: OW];
        return 64'(v);
    endfunction

    function automatic longint acc_lane(int i);
        logic signed [AW-1:0] v;
        v = acc_data[i*AW +: AW];
        return longint'(v);
    endfunction

    // Advance the model using the inputs sampled at this rising edge.
    task automatic model_edge();
        e_we   = 1'b0;
        e_idx  = 0;
        e_done = 1'b0;
        for (int i = 0; i < N; i++) e_q[i] = 0;
        if (!srstn) begin
            m_phase = M_IDLE; m_next = 0; m_sh = 0; m_sat = 0; m_set = 2'd0;
        end else begin
            case (m_phase)
                M_IDLE: if (start) begin
                    m_phase = M_RUN; m_set = data_set_in; m_sh = int'(shift_amt);
                    m_next = 0; m_sat = 0;
                end
                M_RUN: if (acc_valid) begin
                    e_we  = 1'b1;
                    e_idx = m_next;
                    for (int i = 0; i < N; i++) begin
                        longint r = rounded(acc_lane(i), m_sh);
                        e_q[i] = clamp(r);
                        if (e_q[i] != r && m_sat < 65535) m_sat++;
                    end
                    if (m_next == LAST) m_phase = M_END;
                    else m_next++;
                end
                M_END: begin
                    e_done  = 1'b1;
                    m_phase = M_IDLE;
                end
            endcase
        end
        e_busy    = (m_phase != M_IDLE) || e_done;
        m_started = 1;
    endtask

    always @(negedge clk) begin
        if (m_started) begin
            check("busy", 64'(busy), 64'(e_busy));
            check("done", 64'(done), 64'(e_done));
            check("we", 64'(sram_write_enable), 64'(e_we));
            check("index", 64'(matrix_index), 64'(e_idx));
            check("data_set", 64'(data_set), 64'(m_set));
            for (int i = 0; i < N; i++) check($sformatf("lane%0d", i), lane_out(i), e_q[i]);
`ifdef QUANT_SAT_COUNT_EN
            check("sat_count", 64'(sat_count), 64'(m_sat));
`endif
            if (sram_write_enable === 1'b1) n_writes++;
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) acc_data[i*AW +: AW] = lv[i][AW-1:0];
    endtask

    task automatic do_start(input logic [1:0] ds, input logic [4:0] sh);
        start = 1'b1; data_set_in = ds; shift_amt = sh; acc_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    task automatic feed();
        pack();
        acc_valid = 1'b1;
        step();
        acc_valid = 1'b0;
    endtask

    task automatic finish_drain(input int from, input string tag);
        for (int d = from; d <= LAST; d++) begin
            for (int i = 0; i < N; i++) lv[i] = 0;
            lv[0] = d;
            feed();
        end
        step();
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        step();
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        srstn = 1'b0; start = 1'b0; data_set_in = '0; shift_amt = '0;
        acc_valid = 1'b0; acc_data = '0;
        step();
        step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_we", 64'(sram_write_enable), 64'd0);
        check("rst_index", 64'(matrix_index), 64'd0);
        check("rst_lane0", lane_out(0), 64'd0);
        srstn = 1'b1;
        step();

        // Full drain, lane i = i, unshifted.
        n_writes = 0;
        do_start(2'd3, 5'd0);
        check("t1_busy", 64'(busy), 64'd1);
        for (int d = 0; d <= LAST; d++) begin
            for (int i = 0; i < N; i++) lv[i] = i;
            feed();
            check("t1_idx", 64'(matrix_index), 64'(d));
            check("t1_lane15", lane_out(15), 64'd15);
        end
        check("t1_done_not_early", 64'(done), 64'd0);
        step();
        check("t1_done", 64'(done), 64'd1);
        step();
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_writes", 64'(n_writes), 64'd31);
        check("t1_set_held", 64'(data_set), 64'd3);

        // Rounding with shift 4.
        do_start(2'd0, 5'd4);
        for (int i = 0; i < N; i++) lv[i] = 0;
        lv[0] = 24; lv[1] = -24; lv[2] = 8; lv[3] = -9;
        feed();
        check("t2_pos", lane_out(0), 64'd2);
        check("t2_neg", lane_out(1), -64'sd1);
        check("t2_half", lane_out(2), 64'd1);
        check("t2_neg9", lane_out(3), -64'sd1);
        finish_drain(1, "t2");

        // Saturation.
        do_start(2'd1, 5'd0);
        for (int i = 0; i < N; i++) lv[i] = 0;
        lv[0] = longint'(1) << 30; lv[1] = -(longint'(1) << 30);
        feed();
        check("t3_max", lane_out(0), 64'd8388607);
        check("t3_min", lane_out(1), -64'sd8388608);
        finish_drain(1, "t3");
`ifdef QUANT_SAT_COUNT_EN
        check("t3_sat_count", 64'(sat_count), 64'd2);
`endif

        // Stall of 3 cycles after index 5.
        n_writes = 0;
        do_start(2'd2, 5'd0);
        for (int d = 0; d <= 5; d++) begin
            for (int i = 0; i < N; i++) lv[i] = d*16 + i;
            feed();
        end
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_stall_we", 64'(sram_write_enable), 64'd0);
        end
        lv[0] = 6;
        feed();
        check("t4_resume_idx", 64'(matrix_index), 64'd6);
        finish_drain(7, "t4");
        check("t4_writes", 64'(n_writes), 64'd31);

        // Reset mid-drain at index 10.
        do_start(2'd3, 5'd0);
        for (int d = 0; d <= 9; d++) begin
            for (int i = 0; i < N; i++) lv[i] = -d;
            feed();
        end
        srstn = 1'b0;
        feed();
        srstn = 1'b1;
        check("t5_rst_we", 64'(sram_write_enable), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_set", 64'(data_set), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_no_done", 64'(done), 64'd0);
        end
        do_start(2'd1, 5'd0);
        lv[0] = 77;
        feed();
        check("t5_new_idx", 64'(matrix_index), 64'd0);
        check("t5_new_set", 64'(data_set), 64'd1);
        finish_drain(1, "t5");

        // Start pulse during drain is ignored.
        do_start(2'd3, 5'd0);
        for (int d = 0; d <= 4; d++) begin
            lv[0] = d;
            feed();
        end
        start = 1'b1; data_set_in = 2'd2;
        lv[0] = 5;
        feed();
        start = 1'b0;
        check("t6_idx", 64'(matrix_index), 64'd5);
        check("t6_set", 64'(data_set), 64'd3);
        finish_drain(6, "t6");
        check("t6_set_after", 64'(data_set), 64'd3);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
